// File: rtl/quant_pkg.sv
// Shared helpers for the activation quantizer/dequantizer pair and their reference models.
package quant_pkg;

  localparam int unsigned DefNoCh   = 10;
  localparam int unsigned DefBwQ    = 3;
  localparam int unsigned DefSBw    = 8;
  localparam int unsigned DefSFrac  = 4;
  localparam int unsigned DefBwOut  = 12;
  localparam int unsigned DefCntBw  = 16;

  // Internal signed width wide enough for code*scale + offset without overflow.
  function automatic int unsigned dq_width(input int unsigned bw_q, input int unsigned s_bw,
                                           input int unsigned bw_out, input int unsigned s_frac);
    int unsigned prod_w;
    int unsigned off_w;
    prod_w = bw_q + s_bw + 1;
    off_w  = bw_out + s_frac;
    return ((prod_w > off_w) ? prod_w : off_w) + 1;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned bw_out);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw_out - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/dequant_lane.sv
// One channel of the dequantizer: combinational multiply, add offset, floor-shift and clamp.
module dequant_lane
  import quant_pkg::*;
#(
  parameter int unsigned BW_Q   = 3,
  parameter int unsigned S_BW   = 8,
  parameter int unsigned S_FRAC = 4,
  parameter int unsigned BW_OUT = 12
) (
  input  logic        [BW_Q-1:0]          code,
  input  logic signed [S_BW-1:0]          scale,
  input  logic signed [BW_OUT+S_FRAC-1:0] offset,
  output logic signed [BW_OUT-1:0]        value,
  output logic                            sat
);

  localparam int unsigned W = dq_width(BW_Q, S_BW, BW_OUT, S_FRAC);

  logic signed [W-1:0] code_x;
  logic signed [W-1:0] scale_x;
  logic signed [W-1:0] offset_x;
  logic signed [W-1:0] prod;
  logic signed [W-1:0] acc;
  logic signed [W-1:0] shifted;
  logic signed [63:0]  wide;
  logic signed [63:0]  clamped;

  always_comb begin
    code_x   = $signed({{(W-BW_Q){1'b0}}, code});
    scale_x  = {{(W-S_BW){scale[S_BW-1]}}, scale};
    offset_x = {{(W-BW_OUT-S_FRAC){offset[BW_OUT+S_FRAC-1]}}, offset};
    prod     = code_x * scale_x;
    acc      = prod + offset_x;
    // Arithmetic shift floors toward -inf, so -1/16 maps to -1, not 0.
    shifted  = acc >>> S_FRAC;
    wide     = {{(64-W){shifted[W-1]}}, shifted};
    clamped  = sat_signed(wide, BW_OUT);
    value    = clamped[BW_OUT-1:0];
    sat      = (clamped != wide);
  end

endmodule

// File: rtl/quantize_dequant.sv
// Two-stage valid/ready dequantizer: s1 captures codes and per-channel affine params,
// s2 holds the clamped fixed-point result and feeds the saturation counter.
module quantize_dequant
  import quant_pkg::*;
#(
  parameter int unsigned NO_CH  = 10,
  parameter int unsigned BW_Q   = 3,
  parameter int unsigned S_BW   = 8,
  parameter int unsigned S_FRAC = 4,
  parameter int unsigned BW_OUT = 12,
  parameter int unsigned CNT_BW = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    vld_in,
  output logic                                    rdy_in,
  input  logic [NO_CH-1:0][BW_Q-1:0]              data_in,
  input  logic [NO_CH-1:0][S_BW-1:0]              scale,
  input  logic [NO_CH-1:0][BW_OUT+S_FRAC-1:0]     offset,
  output logic                                    vld_out,
  input  logic                                    rdy_out,
  output logic [NO_CH-1:0][BW_OUT-1:0]            data_out,
  output logic [CNT_BW-1:0]                       sat_cnt
);

  logic                                s1_vld;
  logic [NO_CH-1:0][BW_Q-1:0]          s1_code;
  logic [NO_CH-1:0][S_BW-1:0]          s1_scale;
  logic [NO_CH-1:0][BW_OUT+S_FRAC-1:0] s1_offset;
  logic                                s2_sat;

  logic [NO_CH-1:0][BW_OUT-1:0]        lane_val;
  logic [NO_CH-1:0]                    lane_sat;
  logic                                any_sat;
  logic                                s1_load;
  logic                                s2_load;

  for (genvar i = 0; i < NO_CH; i++) begin : g_lane
    dequant_lane #(
      .BW_Q   (BW_Q),
      .S_BW   (S_BW),
      .S_FRAC (S_FRAC),
      .BW_OUT (BW_OUT)
    ) u_lane (
      .code   (s1_code[i]),
      .scale  ($signed(s1_scale[i])),
      .offset ($signed(s1_offset[i])),
      .value  (lane_val[i]),
      .sat    (lane_sat[i])
    );
  end

  // rdy_in deliberately depends combinationally on rdy_out so a full pipe can stream.
  always_comb begin
    any_sat = |lane_sat;
    s2_load = s1_vld && (!vld_out || rdy_out);
    rdy_in  = !rst && (!s1_vld || s2_load);
    s1_load = vld_in && rdy_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_code   <= '0;
      s1_scale  <= '0;
      s1_offset <= '0;
      vld_out   <= 1'b0;
      data_out  <= '0;
      s2_sat    <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      if (s1_load) begin
        s1_vld    <= 1'b1;
        s1_code   <= data_in;
        s1_scale  <= scale;
        s1_offset <= offset;
      end else if (s2_load) begin
        s1_vld <= 1'b0;
      end

      if (s2_load) begin
        vld_out  <= 1'b1;
        data_out <= lane_val;
        s2_sat   <= any_sat;
        if (any_sat && (sat_cnt != '1)) begin
          sat_cnt <= sat_cnt + 1'b1;
        end
      end else if (rdy_out) begin
        vld_out <= 1'b0;
      end
    end
  end

  // A flagged vector in s2 always has been counted, since the counter never wraps.
  sat_flag_counted: assert property (@(posedge clk) disable iff (rst) s2_sat |-> (sat_cnt != '0));

endmodule
